param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, data word width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, entries; a power of two and at least 4.
REQ-003 The block SHALL have parameter AF_THRESH, default FIFO_DEPTH-1, almostfull threshold.
REQ-004 The block SHALL have parameter AE_THRESH, default 1, almostempty threshold.
REQ-005 The block SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- flush  in  1  synchronous clear of contents.
- data_out  out  FIFO_WIDTH  read data.
- wr_ack  out  1  registered pulse: previous-cycle write accepted.
- overflow  out  1  registered pulse: previous-cycle write rejected.
- underflow  out  1  registered pulse: previous-cycle read rejected.
- full, empty, almostfull, almostempty  out  1 each  combinational status from count.
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-006 A write SHALL be accepted when wr_en=1 and count<FIFO_DEPTH; data_in is stored at wr_ptr, and wr_ptr advances at the rising edge.
REQ-007 A read SHALL be accepted when rd_en=1 and count>0; rd_ptr advances, and data_out loads the head word at the same edge (1-cycle latency).
REQ-008 Pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-009 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-010 When full with wr_en=rd_en=1, only the read SHALL occur; count becomes FIFO_DEPTH-1 and overflow=1.
REQ-011 When empty with wr_en=rd_en=1, only the write SHALL occur; count becomes 1 and underflow=1.
REQ-012 wr_ack, overflow and underflow SHALL each be high for exactly the one cycle following the causing edge, and low otherwise.
REQ-013 Status outputs SHALL be:
- full = (count==FIFO_DEPTH).
- empty = (count==0).
- almostfull = (count>=AF_THRESH) and not full.
- almostempty = (count<=AE_THRESH) and not empty.
REQ-014 flush=1 SHALL, at the edge, zero the pointers and count, suppress any write or read that cycle, and leave wr_ack, overflow and underflow low; data_out holds its value.
REQ-015 Rejected operations SHALL not modify the memory, the pointers, count or data_out.

Reset
REQ-016 rst_n=0 SHALL immediately, independent of clk, clear the pointers, count, data_out, wr_ack, overflow and underflow to 0; empty=1, full=0.
REQ-017 Assertion of rst_n mid-operation SHALL discard all contents; memory contents need not be cleared.
REQ-018 On rst_n deassertion, the first edge SHALL be able to accept a write.

Configuration
REQ-019 Macro FIFO_FWFT_EN SHALL select first-word-fall-through mode: data_out combinationally equals the head entry whenever empty=0, and an accepted read only advances rd_ptr.
REQ-020 Without FIFO_FWFT_EN, data_out SHALL be registered per REQ-007, and all other behaviour SHALL be identical in both modes.

Structure
REQ-021 Package fifo_pkg SHALL hold the default width and depth constants and a fifo_status_t struct of the five status flags.
REQ-022 Storage SHALL be a sub-module fifo_mem: a FIFO_DEPTH x FIFO_WIDTH array with one synchronous write port and one read port.
REQ-023 Pointer, count and flag logic SHALL reside in param_fifo.

Verification
REQ-024 The bench SHALL cover the following scenarios, all at default parameters:
- Reset, then write 121, 122, 123, then 3 reads: data_out 121, 122, 123 on successive cycles (1 cycle later without FWFT); count 3->0; empty=1; a 4th read gives underflow=1 for one cycle.
- 8 writes from empty: full=1 at count 8, almostfull=1 at count 7; a 9th write gives overflow=1, wr_ack=0, count stays 8.
- Full FIFO with wr_en=rd_en=1: count becomes 7, overflow=1, and the oldest word is output.
- Empty FIFO with wr_en=rd_en=1 and data_in=0xABCD: count=1, underflow=1, and the next read returns 0xABCD.
- 5 writes, then flush together with wr_en=1: count=0, empty=1, wr_ack=0, data_out unchanged.
- Assert rst_n low between clock edges after 4 writes: count=0, empty=1 without waiting for an edge; 12 writes and 12 reads across the wrap then return data in order.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and status bundle.
// Build with FIFO_FWFT_EN defined for first-word-fall-through reads.
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
    logic overflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port,
// one asynchronous read port, no reset on the array.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with status flags.
// FIFO_FWFT_EN selects first-word-fall-through output.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [FIFO_WIDTH-1:0]       data_in,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic                        flush,
  output logic [FIFO_WIDTH-1:0]       data_out,
  output logic                        wr_ack,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        full,
  output logic                        empty,
  output logic                        almostfull,
  output logic                        almostempty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt_q;
  logic [FIFO_WIDTH-1:0] head;
  logic                  wr_ok, rd_ok;
  logic                  ack_q, ovf_q, udf_q;
  fifo_status_t          st;

  always_comb begin
    st             = '0;
    st.full        = (cnt_q == DEPTH_C);
    st.empty       = (cnt_q == '0);
    st.almostfull  = (cnt_q >= AF_C) && !st.full;
    st.almostempty = (cnt_q <= AE_C) && !st.empty;
    st.overflow    = ovf_q;
  end

  // Flush wins over both requests; full/empty gate each side independently.
  assign wr_ok = wr_en && !st.full && !flush;
  assign rd_ok = rd_en && !st.empty && !flush;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      ack_q <= wr_ok;
      ovf_q <= wr_en && st.full;
      udf_q <= rd_en && st.empty;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        wr_ok && !rd_ok: cnt_q <= cnt_q + CW'(1);
        rd_ok && !wr_ok: cnt_q <= cnt_q - CW'(1);
        default:         cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = st.empty ? '0 : head;
`else
  logic [FIFO_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dout_q <= '0;
    else if (rd_ok) dout_q <= head;
  end

  assign data_out = dout_q;
`endif

  assign wr_ack      = ack_q;
  assign overflow    = st.overflow;
  assign underflow   = udf_q;
  assign full        = st.full;
  assign empty       = st.empty;
  assign almostfull  = st.almostfull;
  assign almostempty = st.almostempty;
  assign count       = cnt_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at default parameters
// (registered-output build).
module tb_param_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] data_out;
  logic        wr_ack, overflow, underflow;
  logic        full, empty, almostfull, almostempty;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  param_fifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .flush       (flush),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ack", wr_ack, 0);
    chk("rst_ae", almostempty, 0);
    #6 rst_n = 1'b1;

    // 121,122,123 then reads
    @(negedge clk);
    wr_en = 1'b1;
    data_in = 16'd121;
    tick();
    chk("w1_ack", wr_ack, 1);
    chk("w1_cnt", count, 1);
    chk("w1_ae", almostempty, 1);
    data_in = 16'd122;
    tick();
    data_in = 16'd123;
    tick();
    chk("w3_cnt", count, 3);
    chk("w3_ae", almostempty, 0);
    idle();
    rd_en = 1'b1;
    tick();
    chk("r1_ack", wr_ack, 0);
    chk("r1_dout", data_out, 121);
    chk("r1_cnt", count, 2);
    tick();
    chk("r2_dout", data_out, 122);
    chk("r2_cnt", count, 1);
    tick();
    chk("r3_dout", data_out, 123);
    chk("r3_cnt", count, 0);
    chk("r3_empty", empty, 1);
    chk("r3_udf", underflow, 0);
    tick();
    chk("r4_udf", underflow, 1);
    chk("r4_dout", data_out, 123);
    chk("r4_cnt", count, 0);
    idle();
    tick();
    chk("r5_udf", underflow, 0);

    // fill to full
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 16'h0100 + 16'(i);
      tick();
      if (i == 7) begin
        chk("f7_af", almostfull, 1);
        chk("f7_full", full, 0);
        chk("f7_cnt", count, 7);
      end
    end
    chk("f8_full", full, 1);
    chk("f8_af", almostfull, 0);
    chk("f8_cnt", count, 8);
    data_in = 16'hDEAD;
    tick();
    chk("f9_ovf", overflow, 1);
    chk("f9_ack", wr_ack, 0);
    chk("f9_cnt", count, 8);

    // full with read+write
    data_in = 16'hBEEF;
    rd_en = 1'b1;
    tick();
    chk("fr_cnt", count, 7);
    chk("fr_ovf", overflow, 1);
    chk("fr_ack", wr_ack, 0);
    chk("fr_dout", data_out, 16'h0101);
    wr_en = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("drain", data_out, 16'h0100 + 32'(i));
    end
    chk("drain_cnt", count, 0);
    chk("drain_ovf", overflow, 0);

    // empty with read+write
    wr_en = 1'b1;
    data_in = 16'hABCD;
    tick();
    chk("er_cnt", count, 1);
    chk("er_udf", underflow, 1);
    chk("er_ack", wr_ack, 1);
    chk("er_dout", data_out, 16'h0108);
    wr_en = 1'b0;
    tick();
    chk("er_rd", data_out, 16'hABCD);
    chk("er_cnt0", count, 0);
    chk("er_udf0", underflow, 0);
    idle();

    // flush with write pending
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'h0050 + 16'(i);
      tick();
    end
    chk("fl5_cnt", count, 5);
    flush = 1'b1;
    data_in = 16'h0077;
    tick();
    chk("fl_cnt", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_ack", wr_ack, 0);
    chk("fl_dout", data_out, 16'hABCD);
    flush = 1'b0;
    data_in = 16'h0099;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    chk("fl_rd", data_out, 16'h0099);
    idle();

    // async reset mid-operation, then wrap
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 16'h0040 + 16'(i);
      tick();
    end
    chk("ar_cnt4", count, 4);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cnt", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_dout", data_out, 0);
    #2 rst_n = 1'b1;
    wr_en = 1'b1;
    data_in = 16'h0600;
    tick();
    chk("ar_ack", wr_ack, 1);
    for (int i = 1; i < 6; i++) begin
      data_in = 16'h0600 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("wrap_a", data_out, 16'h0600 + 32'(i));
    end
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 6; i < 12; i++) begin
      data_in = 16'h0600 + 16'(i);
      tick();
    end
    chk("wrap_cnt", count, 6);
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 6; i < 12; i++) begin
      tick();
      chk("wrap_b", data_out, 16'h0600 + 32'(i));
    end
    chk("wrap_empty", empty, 1);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
